// File: rtl/wallace_mul_pipe.sv
// Three-stage pipelined WIDTH x WIDTH Wallace-tree multiplier with valid/ready flow control.
// Define WALLACE_MUL_SIGNED_EN to honour in_signed (Baugh-Wooley two's-complement products).
module wallace_mul_pipe #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod
);
  localparam int PW   = 2*WIDTH;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam int NR   = WIDTH + 1;  // partial-product rows plus the sign-correction row
`else
  localparam int NR   = WIDTH;
`endif
  localparam int LVLS = 8;          // 3:2 levels needed for 17 rows is 6

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  logic [2:0]    vld_pipe;
  logic          load0, load1, load2;
  req_t          req0;
  logic [PW-1:0] sum_c, cry_c, sum1, cry1;

`ifdef WALLACE_MUL_SIGNED_EN
  logic          sgn0;
`else
  logic          unused_sgn;
  assign unused_sgn = in_signed;
`endif

  assign load2     = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign load1     = vld_pipe[0] & (~vld_pipe[1] | load2);
  assign in_ready  = ~vld_pipe[0] | load1;
  assign load0     = in_valid & in_ready;
  assign out_valid = vld_pipe[2];

  // Row-wise Wallace reduction: every level turns each group of three rows
  // into a sum row and a shifted carry row until two rows remain.
  always_comb begin
    logic [PW-1:0] rows [NR];
    logic [PW-1:0] nxt  [NR];
    int n, q, r;
    for (int i = 0; i < NR; i++) begin
      rows[i] = '0;
      nxt[i]  = '0;
    end
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
`ifdef WALLACE_MUL_SIGNED_EN
        rows[i][i+j] = (req0.a[j] & req0.b[i]) ^ (sgn0 & ((i == WIDTH-1) != (j == WIDTH-1)));
    // Baugh-Wooley constant: ones at columns WIDTH and 2*WIDTH-1
    rows[WIDTH][WIDTH] = sgn0;
    rows[WIDTH][PW-1]  = sgn0;
`else
        rows[i][i+j] = req0.a[j] & req0.b[i];
`endif
    n = NR;
    for (int l = 0; l < LVLS; l++) begin
      if (n > 2) begin
        q = n / 3;
        r = n % 3;
        for (int i = 0; i < NR; i++) nxt[i] = '0;
        for (int g = 0; g < NR/3; g++)
          if (g < q) begin
            nxt[2*g]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
            nxt[2*g+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                          (rows[3*g+1] & rows[3*g+2])) << 1;
          end
        for (int k = 0; k < 2; k++)
          if (k < r) nxt[2*q+k] = rows[3*q+k];
        for (int i = 0; i < NR; i++) rows[i] = nxt[i];
        n = 2*q + r;
      end
    end
    sum_c = rows[0];
    cry_c = rows[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      req0     <= '0;
      sum1     <= '0;
      cry1     <= '0;
      out_prod <= '0;
`ifdef WALLACE_MUL_SIGNED_EN
      sgn0     <= 1'b0;
`endif
    end else begin
      if (load0) begin
        req0 <= '{a: in_a, b: in_b};
`ifdef WALLACE_MUL_SIGNED_EN
        sgn0 <= in_signed;
`endif
      end
      if (load1) begin
        sum1 <= sum_c;
        cry1 <= cry_c;
      end
      if (load2) out_prod <= sum1 + cry1;
      vld_pipe[0] <= load0 | (vld_pipe[0] & ~load1);
      vld_pipe[1] <= load1 | (vld_pipe[1] & ~load2);
      vld_pipe[2] <= load2 | (vld_pipe[2] & ~out_ready);
    end
  end
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe: a WIDTH=6 instance for directed/streaming/backpressure/reset
// steps and a WIDTH=4 instance for the exhaustive sweep.
module tb_wallace_mul_pipe;
`ifdef WALLACE_MUL_SIGNED_EN
  localparam bit SEN = 1'b1;
`else
  localparam bit SEN = 1'b0;
`endif

  logic clk, rst_n;
  logic iv6, ir6, s6, ov6, or6;
  logic [5:0]  a6, b6;
  logic [11:0] p6;
  logic iv4, ir4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  wallace_mul_pipe #(.WIDTH(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .in_a(a6), .in_b(b6),
    .in_signed(s6), .out_valid(ov6), .out_ready(or6), .out_prod(p6));
  wallace_mul_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .out_valid(ov4), .out_ready(or4), .out_prod(p4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int stall6 = 0;
  int outs6 = 0, outs4 = 0, base;
  logic [11:0] q6 [$];
  logic [7:0]  q4 [$];
  logic [11:0] pend6, held;
  logic [7:0]  pend4;
  logic [5:0]  ra, rb;
  logic        rs, done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product, reduced modulo 2^(2w)
  function automatic logic [31:0] mref(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic s);
    longint ax, bx, p;
    ax = longint'(a);
    bx = longint'(b);
    if (SEN && s) begin
      if (a[w-1]) ax = ax - (longint'(1) << w);
      if (b[w-1]) bx = bx - (longint'(1) << w);
    end
    p = (ax * bx) & ((longint'(1) << (2*w)) - 1);
    return 32'(p);
  endfunction

  always @(negedge clk) begin
    if (ov6 && or6) begin
      chk("sb6_has_entry", 32'(q6.size() != 0), 1);
      if (q6.size() != 0) chk("prod6", 32'(p6), 32'(q6.pop_front()));
      outs6++;
    end
    if (ov4 && or4) begin
      chk("sb4_has_entry", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) chk("prod4", 32'(p4), 32'(q4.pop_front()));
      outs4++;
    end
  end

  task automatic drive6(input logic [5:0] a, input logic [5:0] b, input logic s, input logic [11:0] e);
    iv6 = 1'b1; a6 = a; b6 = b; s6 = s; pend6 = e;
  endtask

  task automatic acc6();
    int t = 0;
    @(negedge clk);
    while (!ir6 && t < 50) begin t++; stall6++; @(negedge clk); end
    if (t >= 50) chk("accept6_timeout", 32'(t), 0);
    else q6.push_back(pend6);
    @(posedge clk); #1;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] e);
    iv4 = 1'b1; a4 = a; b4 = b; s4 = s; pend4 = e;
  endtask

  task automatic acc4();
    int t = 0;
    @(negedge clk);
    while (!ir4 && t < 50) begin t++; @(negedge clk); end
    if (t >= 50) chk("accept4_timeout", 32'(t), 0);
    else q4.push_back(pend4);
    @(posedge clk); #1;
  endtask

  task automatic drain6(input string tag);
    int t = 0;
    while (q6.size() != 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    chk(tag, 32'(q6.size()), 0);
  endtask

  task automatic drain4(input string tag);
    int t = 0;
    while (q4.size() != 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    chk(tag, 32'(q4.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; done = 1'b0;
    iv6 = 0; a6 = '0; b6 = '0; s6 = 0; or6 = 1'b1;
    iv4 = 0; a4 = '0; b4 = '0; s4 = 0; or4 = 1'b1;
    #3;
    chk("rst_out_valid", 32'(ov6), 0);
    chk("rst_in_ready", 32'(ir6), 1);
    chk("rst_prod", 32'(p6), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // single transaction latency
    drive6(6'd63, 6'd63, 1'b0, 12'hF81); acc6(); iv6 = 1'b0;
    chk("lat_edge_k", 32'(ov6), 0);
    @(posedge clk); #1; chk("lat_edge_k1", 32'(ov6), 0);
    @(posedge clk); #1; chk("lat_edge_k2", 32'(ov6), 1);
    chk("lat_prod", 32'(p6), 32'h0F81);

    // directed products, spec-table values
    drive6(6'd3, 6'd5, 1'b0, 12'd15); acc6();
    drive6(6'h20, 6'h1F, 1'b1, SEN ? 12'hC20 : 12'd992); acc6();
    drive6(6'h20, 6'h20, 1'b1, 12'h400); acc6();
    drive6(6'h20, 6'h1F, 1'b0, 12'd992); acc6();
    drive6(6'h3F, 6'h3F, 1'b1, SEN ? 12'd1 : 12'hF81); acc6();
    iv6 = 1'b0;
    drain6("drain_directed");

    // back-to-back stream
    stall6 = 0; base = outs6;
    for (int i = 0; i < 100; i++) begin
      ra = 6'($urandom); rb = 6'($urandom); rs = 1'($urandom);
      drive6(ra, rb, rs, 12'(mref(6, 16'(ra), 16'(rb), rs))); acc6();
    end
    iv6 = 1'b0;
    chk("stream_stalls", 32'(stall6), 0);
    drain6("drain_stream");
    chk("stream_count", 32'(outs6 - base), 100);

    // backpressure: three accepts fill the pipe
    or6 = 1'b0;
    drive6(6'd1, 6'd2, 1'b0, 12'd2);  acc6();
    drive6(6'd3, 6'd4, 1'b0, 12'd12); acc6();
    drive6(6'd5, 6'd6, 1'b0, 12'd30); acc6();
    drive6(6'd7, 6'd8, 1'b0, 12'd56);
    @(negedge clk);
    chk("bp_in_ready_low", 32'(ir6), 0);
    chk("bp_out_valid", 32'(ov6), 1);
    held = p6;
    chk("bp_first_prod", 32'(held), 2);
    repeat (3) @(negedge clk);
    chk("bp_prod_hold", 32'(p6), 32'(held));
    chk("bp_still_full", 32'(ir6), 0);
    @(posedge clk); #1;
    or6 = 1'b1; #1;
    chk("bp_ready_same_cycle", 32'(ir6), 1);
    acc6(); iv6 = 1'b0;
    drain6("drain_backpressure");

    // random out_ready toggling
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = 6'($urandom); rb = 6'($urandom); rs = 1'($urandom);
          drive6(ra, rb, rs, 12'(mref(6, 16'(ra), 16'(rb), rs))); acc6();
        end
        iv6 = 1'b0; done = 1'b1;
      end
      begin
        while (!done) begin or6 = 1'($urandom_range(0, 1)); @(posedge clk); #1; end
      end
    join
    or6 = 1'b1;
    drain6("drain_toggle");

    // reset with two transactions in flight
    or6 = 1'b0;
    drive6(6'd9, 6'd9, 1'b0, 12'd81); acc6();
    drive6(6'd10, 6'd10, 1'b0, 12'd100); acc6(); iv6 = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(ov6), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov6), 0);
    chk("midrst_in_ready", 32'(ir6), 1);
    chk("midrst_prod", 32'(p6), 0);
    q6.delete();
    or6 = 1'b1;
    #10 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(ov6), 0);

    // exhaustive WIDTH=4 sweep, both modes
    base = outs4;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          drive4(a[3:0], b[3:0], s[0], 8'(mref(4, 16'(a), 16'(b), s[0]))); acc4();
        end
    iv4 = 1'b0;
    drain4("drain_sweep4");
    chk("sweep4_count", 32'(outs4 - base), 512);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
